// File: rtl/fact_bus_pkg.sv
// Shared address map, register offsets and accelerator state encoding
// for the factorial bus subsystem.
package fact_bus_pkg;
  localparam logic [7:0] MEM_PAGE  = 8'h00;
  localparam logic [7:0] FACT_PAGE = 8'h70;

  localparam logic [4:0] OPSTART  = 5'd0;
  localparam logic [4:0] OPCLEAR  = 5'd1;
  localparam logic [4:0] OPDONE   = 5'd2;
  localparam logic [4:0] INTR_EN  = 5'd3;
  localparam logic [4:0] OPERAND  = 5'd4;
  localparam logic [4:0] RESULT_H = 5'd5;
  localparam logic [4:0] RESULT_L = 5'd6;

  typedef enum logic [1:0] {IDLE, INIT, MUL, DONE} fact_state_e;
endpackage

// File: rtl/fact_mul_step.sv
// Multi-cycle shift-add multiplier: 128-bit a times MUL_BITS-bit b, truncated
// to 128 bits. The first partial product is taken on the start edge.
module fact_mul_step #(
  parameter int MUL_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic [127:0]        a,
  input  logic [MUL_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [127:0]        product
);
  localparam int CW = $clog2(MUL_BITS + 1);

  logic [127:0]        mcand, acc;
  logic [MUL_BITS-1:0] mplier;
  logic [CW-1:0]       cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (start) begin
        acc    <= b[0] ? a : '0;
        mcand  <= a << 1;
        mplier <= b >> 1;
        cnt    <= CW'(MUL_BITS - 1);
      end else if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign busy    = (cnt != '0);
  assign product = acc;
endmodule

// File: rtl/fact_bus_top.sv
// Single-master bus with 64-bit data memory and a memory-mapped factorial
// accelerator. Define FACT_INTERRUPT_EN to enable the INTR_EN register and interrupt.
module fact_bus_top
  import fact_bus_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int MUL_BITS  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [15:0] m_addr,
  input  logic [63:0] m_dout,
  output logic        m_grant,
  output logic [63:0] m_din,
  output logic        interrupt
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [63:0]  mem [MEM_DEPTH];
  fact_state_e  state_q, state_d;
  logic [63:0]  operand, n, rdata;
  logic [127:0] result, mul_product;
  logic         intr_en, mul_start, mul_busy, mul_done;
  logic         active, done, busy, mem_sel, fact_sel;
  logic         fact_wr, start_wr, clear_wr;
  logic [7:0]   page;
  logic [4:0]   off;
  logic         unused_addr;

  assign page        = m_addr[15:8];
  assign off         = m_addr[7:3];
  assign unused_addr = ^m_addr[2:0];
  assign active      = m_req & m_grant;
  assign mem_sel     = (page == MEM_PAGE);
  assign fact_sel    = (page == FACT_PAGE);
  assign fact_wr     = active & m_wr & fact_sel;
  assign start_wr    = fact_wr & (off == OPSTART) & m_dout[0];
  assign clear_wr    = fact_wr & (off == OPCLEAR) & m_dout[0];
  assign done        = (state_q == DONE);
  assign busy        = (state_q == INIT) || (state_q == MUL);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      m_grant <= 1'b0;
      m_din   <= '0;
    end else begin
      m_grant <= m_req;
      m_din   <= (active && !m_wr) ? rdata : '0;
    end
  end

  always_ff @(posedge clk)
    if (active && m_wr && mem_sel) mem[m_addr[AW-1:0]] <= m_dout;

  always_comb begin
    rdata = '0;
    if (mem_sel) begin
      rdata = mem[m_addr[AW-1:0]];
    end else if (fact_sel) begin
      case (off)
        OPDONE:   rdata = {62'd0, busy, done};
        INTR_EN:  rdata = {63'd0, intr_en};
        OPERAND:  rdata = operand;
        RESULT_H: rdata = result[127:64];
        RESULT_L: rdata = result[63:0];
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;

  // Clear wins over everything; a new multiply step launches whenever MUL is
  // neither running one nor retiring one.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    if (clear_wr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_wr) state_d = INIT;
        INIT: state_d = (n <= 64'd1) ? DONE : MUL;
        MUL: begin
          mul_start = !mul_busy && !mul_done;
          if (mul_done && n <= 64'd2) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // n and result are snapshotted at start so later OPERAND writes cannot
  // disturb a running computation.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      operand <= '0;
      n       <= '0;
      result  <= '0;
    end else begin
      if (fact_wr && off == OPERAND) operand <= m_dout;
      if (clear_wr) begin
        n      <= '0;
        result <= '0;
      end else if (state_q == IDLE && start_wr) begin
        n      <= operand;
        result <= 128'd1;
      end else if (state_q == MUL && mul_done) begin
        result <= mul_product;
        n      <= n - 64'd1;
      end
    end
  end

`ifdef FACT_INTERRUPT_EN
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      intr_en   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (fact_wr && off == INTR_EN) intr_en <= m_dout[0];
      interrupt <= done & intr_en;
    end
  end
`else
  assign intr_en   = 1'b0;
  assign interrupt = 1'b0;
`endif

  fact_mul_step #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk     (clk),
    .rst     (reset_n),
    .clear   (clear_wr),
    .start   (mul_start),
    .a       (result),
    .b       (n[MUL_BITS-1:0]),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
endmodule

// File: tb/tb_fact_bus_top.sv
// Randomized scoreboard bench for fact_bus_top: reads push expected data,
// a negedge monitor pops and compares one cycle after each read access.
module tb_fact_bus_top;
  logic        clk = 1'b0, rst = 1'b1, m_req = 1'b0, m_wr = 1'b0;
  logic [15:0] m_addr = '0;
  logic [63:0] m_dout = '0;
  logic        m_grant, interrupt;
  logic [63:0] m_din;

  always #5 clk = ~clk;

  fact_bus_top dut (
    .clk(clk), .reset_n(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din), .interrupt(interrupt)
  );

`ifdef FACT_INTERRUPT_EN
  localparam bit HAS_INTR = 1'b1;
`else
  localparam bit HAS_INTR = 1'b0;
`endif

  typedef struct {logic [15:0] addr; logic [63:0] exp;} exp_t;
  exp_t        sb[$];
  int          tests = 0, fails = 0;
  logic        rd_strobe = 1'b0, rd_seen = 1'b0;
  logic [63:0] mem_m [256];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] fact(int unsigned k);
    logic [127:0] r;
    r = 128'd1;
    for (int unsigned i = 2; i <= k; i++) r = r * 128'(i);
    return r;
  endfunction

  always @(posedge clk) rd_seen <= rd_strobe;

  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_empty: got read data %h with no expected entry", m_din);
      end else begin
        e = sb.pop_front();
        chk($sformatf("read_%h", e.addr), m_din, e.exp);
      end
    end
  end

  task automatic bus(bit wr, logic [15:0] a, logic [63:0] d, bit strobe);
    @(posedge clk);
    #1 m_wr = wr; m_addr = a; m_dout = d; rd_strobe = strobe;
  endtask

  task automatic bus_wr(logic [15:0] a, logic [63:0] d);
    bus(1'b1, a, d, 1'b0);
  endtask

  task automatic bus_rd(logic [15:0] a, logic [63:0] e);
    bus(1'b0, a, '0, 1'b1);
    sb.push_back('{addr: a, exp: e});
  endtask

  task automatic idle(int cyc);
    repeat (cyc) bus(1'b0, 16'h5000, '0, 1'b0);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      bus(1'b0, 16'h7010, '0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      if (m_din[0]) ok = 1'b1;
    end
    chk("done_seen", 64'(ok), 64'd1);
  endtask

  task automatic check_result(int unsigned op);
    logic [127:0] r;
    r = fact(op);
    bus_rd(16'h7028, r[127:64]);
    bus_rd(16'h7030 | 16'($urandom_range(0, 7)), r[63:0]);
    bus_rd(16'h7035, r[63:0]);
  endtask

  task automatic run(int unsigned op, bit ien);
    bus_wr(16'h7008, 64'd1);
    bus_wr(16'h7020, 64'(op));
    bus_wr(16'h7018, 64'(ien));
    bus_wr(16'h7000, 64'd1);
    bus_rd(16'h7010, 64'd2);
    if (op < 2) bus_rd(16'h7010, 64'd1);
    wait_done();
    chk($sformatf("interrupt_op%0d", op), 64'(interrupt), 64'(HAS_INTR && ien));
    check_result(op);
    bus_rd(16'h7020, 64'(op));
    bus_rd(16'h7018, 64'(HAS_INTR && ien));
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   addrs[12];
    logic [127:0] r;
    logic [63:0]  d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(m_grant), 64'd0);
    chk("rst_din", m_din, 64'd0);
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) chk("grant_idle", 64'(m_grant), 64'd0);
    @(posedge clk); #1 m_req = 1'b1; m_addr = 16'h5000;
    @(negedge clk) chk("grant_delay", 64'(m_grant), 64'd0);
    @(negedge clk) chk("grant_on", 64'(m_grant), 64'd1);

    for (int i = 0; i < 12; i++) begin
      addrs[i] = 8'($urandom_range(0, 255));
      d = {$urandom, $urandom};
      mem_m[addrs[i]] = d;
      bus_wr({8'h00, addrs[i]}, d);
    end
    for (int i = 11; i >= 0; i--) bus_rd({8'h00, addrs[i]}, mem_m[addrs[i]]);
    bus_wr(16'h5008, {$urandom, $urandom});
    bus_rd(16'h5000, 64'd0);
    bus_rd(16'h5008, 64'd0);
    bus_rd(16'h7038, 64'd0);

    run(20, 1'b1);
    run(21, 1'b1);
    r = fact(21);
    bus_wr(16'h0081, r[127:64]);
    bus_wr(16'h0030, r[63:0]);
    bus_rd(16'h0081, 64'h2);
    bus_rd(16'h0030, 64'hC5077D36B8C40000);
    run(0, 1'b1);
    run(1, 1'b0);
    repeat (3) run($urandom_range(2, 40), 1'($urandom_range(0, 1)));
    run(36, 1'b0);

    // clear after done
    run(5, 1'b1);
    bus_wr(16'h7018, 64'd0);
    idle(2);
    @(negedge clk) chk("intr_en_off", 64'(interrupt), 64'd0);
    bus_wr(16'h7018, 64'd1);
    idle(2);
    @(negedge clk) chk("intr_en_on", 64'(interrupt), 64'(HAS_INTR));
    bus_wr(16'h7008, 64'd1);
    bus_rd(16'h7010, 64'd0);
    bus_rd(16'h7028, 64'd0);
    bus_rd(16'h7030, 64'd0);
    bus_rd(16'h7020, 64'd5);
    idle(1);
    @(negedge clk) chk("clear_interrupt", 64'(interrupt), 64'd0);

    // clear mid-computation, then restart with the retained operand
    bus_wr(16'h7020, 64'd25);
    bus_wr(16'h7000, 64'd1);
    idle(100);
    bus_rd(16'h7010, 64'd2);
    bus_wr(16'h7008, 64'd1);
    bus_rd(16'h7010, 64'd0);
    bus_rd(16'h7030, 64'd0);
    idle(300);
    bus_rd(16'h7010, 64'd0);
    bus_wr(16'h7000, 64'd1);
    wait_done();
    check_result(25);

    // operand write and start while busy must not disturb the run
    bus_wr(16'h7008, 64'd1);
    bus_wr(16'h7020, 64'd30);
    bus_wr(16'h7000, 64'd1);
    idle(50);
    bus_wr(16'h7020, 64'd7);
    bus_wr(16'h7000, 64'd1);
    wait_done();
    check_result(30);
    bus_rd(16'h7020, 64'd7);

    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fact_bus_top.md
Name: fact_bus_top

Overview:
- Single-master bus subsystem with two slaves: a 256 x 64-bit data memory and a memory-mapped factorial accelerator.
- The external master requests the bus, gets a grant, then reads and writes 64-bit words by address.
- The accelerator computes operand! as a 128-bit result and can raise an interrupt on completion.

Parameters:
- MEM_DEPTH, 256, number of 64-bit words in data memory; indexed by m_addr[7:0].
- MUL_BITS, 64, operand/multiplier width of the shift-add multiply step.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous reset, active-high: logic 1 resets the block. Port name is kept for codebase consistency.
- m_req  input  1  master bus request.
- m_wr  input  1  1 = write, 0 = read.
- m_addr  input  16  byte address.
- m_dout  input  64  master write data.
- m_grant  output  1  bus grant.
- m_din  output  64  read data to master.
- interrupt  output  1  factorial-done interrupt.

Behaviour:
- Reset: m_grant=0, m_din=0, interrupt=0. All accelerator registers are 0. Memory contents are not reset.
- Grant: m_grant is registered and equals m_req delayed by 1 cycle. An access is active in a cycle where m_req & m_grant are both 1.
- Address decode:
  - m_addr[15:8]==8'h00 selects memory word m_addr[7:0].
  - m_addr[15:8]==8'h70 selects an accelerator register at offset m_addr[7:3]; m_addr[2:0] is ignored.
  - All other addresses: reads return 0, writes are ignored.
- Write: an active access with m_wr=1 writes m_dout at the rising edge.
- Read: an active access with m_wr=0 registers the read data, so m_din is valid 1 cycle after the address. Inactive cycles drive m_din=0.
- Accelerator register map:
  - 0x7000 OPSTART (W): bit0=1 starts when idle; ignored while busy.
  - 0x7008 OPCLEAR (W): bit0=1 is a synchronous soft reset of state, result and done. It does not clear operand or intr_en. It has priority over a start in the same cycle.
  - 0x7010 OPDONE (R): bit0=done, bit1=busy, other bits 0.
  - 0x7018 INTR_EN (R/W): bit0 only.
  - 0x7020 OPERAND (R/W): 64 bits.
  - 0x7028 RESULT_H (R): result[127:64].
  - 0x7030 RESULT_L (R): result[63:0].
- Accelerator FSM states: IDLE, INIT, MUL, DONE.
  - IDLE -> INIT on start.
  - INIT: result=1, n=operand, 1 cycle.
  - If n<=1 -> DONE. Otherwise MUL.
  - MUL: result = (result * n) mod 2^128 via sub-module, then n=n-1. Each step takes MUL_BITS+1 cycles.
  - DONE: done=1, busy=0. Remains in DONE until opclear.
  - busy=1 in INIT and MUL.
- Arithmetic: the product is truncated to 128 bits; overflow (operand>34) wraps silently.
- interrupt = done & intr_en[0], registered. It stays high until opclear or intr_en is cleared.
- A write to OPERAND while busy is accepted but does not affect the running computation.
- Asynchronous reset mid-operation aborts to IDLE.

Optional Feature:
- FACT_INTERRUPT_EN
  - Defined: INTR_EN register and interrupt output behave as above.
  - Undefined: INTR_EN reads 0, writes are ignored, and interrupt is tied to 0.

Decomposition:
- Shared package fact_bus_pkg holds:
  - Address constants: MEM_PAGE=8'h00, FACT_PAGE=8'h70.
  - Register offsets: OPSTART=0, OPCLEAR=1, OPDONE=2, INTR_EN=3, OPERAND=4, RESULT_H=5, RESULT_L=6.
  - FSM state enum.
- One natural sub-module: fact_mul_step, a multi-cycle shift-add 128x64 -> 128-bit multiplier with start/done.

Test Plan:
- Reset release: m_grant=0, m_din=0, interrupt=0. Then m_req=1 -> m_grant=1 on the next cycle.
- Write OPERAND=20, INTR_EN=1, OPSTART=1; poll OPDONE -> 2'b10 while busy, then 2'b01. interrupt=1; RESULT_H=0; read at 0x7035 -> RESULT_L=0x21C3677C82B40000.
- Operand 21 -> RESULT_H=0x2, RESULT_L=0xC5077D36B8C40000. Operand 0 and operand 1 -> result=1, done within 3 cycles of start.
- Copy results to memory: write 0x0081 and 0x0030, read back -> identical values. Read unmapped 0x5000 -> 0.
- OPCLEAR=1 after done -> OPDONE=0, result=0, interrupt=0. OPCLEAR mid-computation -> IDLE. Restart gives the correct result.
- intr_en=0 run -> done=1 with interrupt=0. Build without FACT_INTERRUPT_EN -> INTR_EN reads 0 and interrupt stays 0.
